box_shape_drawer: RTL and testbench
===================================

// Module: box_shape_drawer
// PURPOSE
//  Datapath responder to the display control FSM's shape-draw handshake. The FSM pulses
//  loadStartAddress (latch box origin/colour), then startingAddressLoaded (start drawing).
//  The block rasterizes one BOX_W x BOX_H note box into the VGA pixel port, one pixel per
//  cycle, then pulses shapeDone so the FSM advances to the next box or back to waitForSong.
// PARAMETERS
//  BOX_W      4    box width in pixels (>=1)
//  BOX_H      4    box height in pixels (>=1)
//  BOX_X0     40   x origin of box 0
//  BOX_PITCH  40   x distance between adjacent box origins
//  GRID_W     240  visible grid width; x >= GRID_W is clipped
//  GRID_H     180  visible grid height; y >= GRID_H is clipped
//  ON_COLOUR  3'b010  colour of an active-note box;  OFF_COLOUR 3'b111  inactive box
// PORTS
//  clock                  in   1  system clock, all state on posedge
//  reset                  in   1  synchronous, active-low
//  loadStartAddress       in   1  FSM: latch origin/colour for boxIndex
//  startingAddressLoaded  in   1  FSM: begin drawing latched box
//  boxIndex               in   2  FSM boxCounter, selects box 0..3
//  yStart                 in   8  y origin of the box row for this beat
//  noteActive             in   4  bit i = note in box i is currently on
//  x                      out  8  pixel x
//  y                      out  8  pixel y
//  colour                 out  3  pixel colour
//  plot                   out  1  pixel write enable
//  shapeDone              out  1  one-cycle pulse, box finished
//  busy                   out  1  high in LOADED/DRAW/DONE
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; x=0,y=0,colour=0,plot=0,shapeDone=0,busy=0;
//    offsets cleared. Reset mid-draw aborts; no shapeDone is issued.
//  - States: IDLE, LOADED, DRAW, DONE.
//  - IDLE: on loadStartAddress: baseX = BOX_X0 + boxIndex*BOX_PITCH (9-bit), baseY = yStart,
//    colour latched = noteActive[boxIndex] ? ON_COLOUR : OFF_COLOUR; go LOADED.
//    startingAddressLoaded in IDLE is ignored.
//  - LOADED: on startingAddressLoaded -> DRAW with ox=0, oy=0. loadStartAddress here
//    re-latches (last load wins); if both are high, re-latch and go DRAW using new values.
//  - DRAW: each cycle outputs x=baseX+ox, y=baseY+oy (registered, valid with plot).
//    ox counts 0..BOX_W-1 then wraps to 0 and oy increments (raster order, x fastest).
//    After pixel (BOX_W-1, BOX_H-1) -> DONE. Exactly BOX_W*BOX_H DRAW cycles.
//  - Clipping: sums computed at 9 bits; if x>=GRID_W or y>=GRID_H, plot=0 for that cycle
//    (cycle still consumed, x/y show truncated low 8 bits). No wrap-around onto screen.
//  - DONE: shapeDone=1, plot=0 for exactly one cycle -> IDLE.
//  - Latency: startingAddressLoaded at cycle N -> first plot N+1 -> shapeDone N+1+BOX_W*BOX_H.
//  - loadStartAddress / startingAddressLoaded in DRAW or DONE are ignored.
//  - plot is 0 in all states except DRAW.
// CONFIGURATION
//  BOX_OUTLINE_EN defined: plot only on perimeter pixels (ox==0|ox==BOX_W-1|oy==0|
//    oy==BOX_H-1); interior cycles have plot=0. Cycle count and shapeDone timing unchanged.
//  BOX_OUTLINE_EN undefined: filled box, every in-grid pixel plotted.
// TESTING
//  1 Reset: hold reset=0 2 cycles mid-DRAW -> plot=0, shapeDone=0, busy=0, state IDLE.
//  2 Filled box: boxIndex=2, yStart=10, noteActive=4'b0100, load then start ->
//    16 plots, (120,10)..(123,13) raster order, colour 3'b010, shapeDone 17 cycles after start.
//  3 Inactive box: boxIndex=1, noteActive=0 -> origin (80,y), colour 3'b111.
//  4 Clip: yStart=178 -> rows 178,179 plotted (8 plots), rows 180,181 plot=0; shapeDone
//    still 17 cycles after start.
//  5 Protocol: start in IDLE ignored; two loads (idx 0 then 3) in LOADED -> draws box 3 at x=160;
//    load during DRAW does not change x/colour.
//  6 BOX_OUTLINE_EN build, 4x4: 12 plots, pixels (1,1),(2,1),(1,2),(2,2) offsets not plotted.

Source files
------------

// File: rtl/box_shape_drawer_if.sv
`default_nettype none
// ============================================================================
// Module   : box_shape_drawer_if
// Brief    : Shape-draw handshake from the display FSM plus the VGA pixel port.
// Revision : 1.0
// ============================================================================
interface box_shape_drawer_if;
    logic       loadStartAddress;
    logic       startingAddressLoaded;
    logic [1:0] boxIndex;
    logic [7:0] yStart;
    logic [3:0] noteActive;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       shapeDone;
    logic       busy;

    modport master (
        output loadStartAddress, startingAddressLoaded, boxIndex, yStart, noteActive,
        input  x, y, colour, plot, shapeDone, busy
    );

    modport slave (
        input  loadStartAddress, startingAddressLoaded, boxIndex, yStart, noteActive,
        output x, y, colour, plot, shapeDone, busy
    );
endinterface
`default_nettype wire

// File: rtl/box_shape_drawer.sv
`default_nettype none
// ============================================================================
// Module   : box_shape_drawer
// Brief    : Rasterizes one note box per handshake, one pixel per cycle.
//            Optional macro BOX_OUTLINE_EN: plot perimeter pixels only.
// Revision : 1.0
// ============================================================================
module box_shape_drawer #(
    parameter int         BOX_W      = 4,
    parameter int         BOX_H      = 4,
    parameter int         BOX_X0     = 40,
    parameter int         BOX_PITCH  = 40,
    parameter int         GRID_W     = 240,
    parameter int         GRID_H     = 180,
    parameter logic [2:0] ON_COLOUR  = 3'b010,
    parameter logic [2:0] OFF_COLOUR = 3'b111
) (
    input  wire logic           clock,
    input  wire logic           reset,
    box_shape_drawer_if.slave   bus
);

    localparam int c_OXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int c_OYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [c_OXW-1:0] c_OX_LAST = c_OXW'(BOX_W - 1);
    localparam logic [c_OYW-1:0] c_OY_LAST = c_OYW'(BOX_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_DRAW   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_latch;
    logic             w_start;
    logic             w_last;
    logic             w_edge;
    logic             w_in_grid;
    logic [8:0]       w_sum_x;
    logic [8:0]       w_sum_y;
    logic [8:0]       w_base_x_nxt;

    logic [8:0]       r_base_x;
    logic [7:0]       r_base_y;
    logic [2:0]       r_colour_lat;
    logic [c_OXW-1:0] r_ox;
    logic [c_OYW-1:0] r_oy;
    logic [7:0]       r_x;
    logic [7:0]       r_y;
    logic [2:0]       r_colour;
    logic             r_plot;
    logic             r_shape_done;
    logic             r_busy;

    assign w_base_x_nxt = 9'(BOX_X0) + 9'(bus.boxIndex) * 9'(BOX_PITCH);
    assign w_sum_x      = r_base_x + 9'(r_ox);
    assign w_sum_y      = {1'b0, r_base_y} + 9'(r_oy);
    assign w_in_grid    = (32'(w_sum_x) < GRID_W) && (32'(w_sum_y) < GRID_H);
    assign w_last       = (r_ox == c_OX_LAST) && (r_oy == c_OY_LAST);

`ifdef BOX_OUTLINE_EN
    assign w_edge = (r_ox == '0) || (r_ox == c_OX_LAST) ||
                    (r_oy == '0) || (r_oy == c_OY_LAST);
`else
    assign w_edge = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.loadStartAddress) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_LOADED;
                end
            end
            S_LOADED: begin
                // A simultaneous load and start draws with the freshly latched values.
                w_latch = bus.loadStartAddress;
                if (bus.startingAddressLoaded) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_base_x     <= '0;
            r_base_y     <= '0;
            r_colour_lat <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
        end else begin
            if (w_latch) begin
                r_base_x     <= w_base_x_nxt;
                r_base_y     <= bus.yStart;
                r_colour_lat <= bus.noteActive[bus.boxIndex] ? ON_COLOUR : OFF_COLOUR;
            end
            if (w_start) begin
                r_ox <= '0;
                r_oy <= '0;
            end else if (r_state == S_DRAW) begin
                if (r_ox == c_OX_LAST) begin
                    r_ox <= '0;
                    r_oy <= r_oy + 1'b1;
                end else begin
                    r_ox <= r_ox + 1'b1;
                end
            end
        end
    end

    // Pixel port is one register stage behind the offset counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_plot       <= 1'b0;
            r_shape_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_plot       <= (r_state == S_DRAW) && w_in_grid && w_edge;
            r_shape_done <= (r_state == S_DONE);
            r_busy       <= (r_state != S_IDLE);
            if (r_state == S_DRAW) begin
                r_x      <= w_sum_x[7:0];
                r_y      <= w_sum_y[7:0];
                r_colour <= r_colour_lat;
            end
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.colour    = r_colour;
    assign bus.plot      = r_plot;
    assign bus.shapeDone = r_shape_done;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_box_shape_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_box_shape_drawer
// Brief    : Directed self-checking bench for box_shape_drawer.
// Revision : 1.0
// ============================================================================
module tb_box_shape_drawer;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    box_shape_drawer_if u_if ();

    box_shape_drawer u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [1:0] idx, input logic [7:0] ys, input logic [3:0] na);
        u_if.loadStartAddress = 1'b1;
        u_if.boxIndex         = idx;
        u_if.yStart           = ys;
        u_if.noteActive       = na;
        tick();
        u_if.loadStartAddress = 1'b0;
    endtask

    // Start the latched box and check all BOX_W*BOX_H pixel cycles plus the done pulse.
    task automatic draw_box(input int x0, input int y0, input logic [2:0] col,
                            input int exp_plots, input bit poke);
        int  ex, ey, nplot;
        bit  ep;
        nplot = 0;
        u_if.startingAddressLoaded = 1'b1;
        tick();
        u_if.startingAddressLoaded = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            ex = x0 + (i % 4);
            ey = y0 + (i / 4);
            ep = (ex < 240) && (ey < 180);
`ifdef BOX_OUTLINE_EN
            if (((i % 4) == 1 || (i % 4) == 2) && ((i / 4) == 1 || (i / 4) == 2)) ep = 1'b0;
`endif
            chk("x", 32'(u_if.x), ex & 255);
            chk("y", 32'(u_if.y), ey & 255);
            chk("plot", 32'(u_if.plot), 32'(ep));
            chk("done_early", 32'(u_if.shapeDone), 0);
            chk("busy_draw", 32'(u_if.busy), 1);
            if (ep) chk("colour", 32'(u_if.colour), 32'(col));
            if (u_if.plot === 1'b1) nplot++;
            if (poke && i == 5) begin
                u_if.loadStartAddress = 1'b1;
                u_if.boxIndex         = 2'd0;
                u_if.noteActive       = 4'b0000;
            end
            if (poke && i == 6) u_if.loadStartAddress = 1'b0;
            tick();
        end
        chk("shapeDone", 32'(u_if.shapeDone), 1);
        chk("plot_done", 32'(u_if.plot), 0);
        chk("plot_count", nplot, exp_plots);
        tick();
        chk("shapeDone_pulse", 32'(u_if.shapeDone), 0);
        chk("busy_idle", 32'(u_if.busy), 0);
    endtask

    initial begin
        int sd_seen;
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        u_if.loadStartAddress      = 1'b0;
        u_if.startingAddressLoaded = 1'b0;
        u_if.boxIndex              = 2'd0;
        u_if.yStart                = 8'd0;
        u_if.noteActive            = 4'd0;
        tick();
        tick();
        chk("rst_x", 32'(u_if.x), 0);
        chk("rst_y", 32'(u_if.y), 0);
        chk("rst_colour", 32'(u_if.colour), 0);
        chk("rst_plot", 32'(u_if.plot), 0);
        chk("rst_done", 32'(u_if.shapeDone), 0);
        chk("rst_busy", 32'(u_if.busy), 0);
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of a draw aborts it silently.
        load(2'd2, 8'd10, 4'b0100);
        u_if.startingAddressLoaded = 1'b1;
        tick();
        u_if.startingAddressLoaded = 1'b0;
        repeat (5) tick();
        chk("mid_plot", 32'(u_if.plot), 1);
        reset = 1'b0;
        tick();
        tick();
        chk("abort_plot", 32'(u_if.plot), 0);
        chk("abort_done", 32'(u_if.shapeDone), 0);
        chk("abort_busy", 32'(u_if.busy), 0);
        reset = 1'b1;
        sd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.shapeDone !== 1'b0 || u_if.busy !== 1'b0) sd_seen++;
        end
        chk("abort_no_done", sd_seen, 0);

`ifdef BOX_OUTLINE_EN
        // Filled-box and inactive-box draws in outline form.
        load(2'd2, 8'd10, 4'b0100);
        draw_box(120, 10, 3'b010, 12, 1'b0);
        load(2'd1, 8'd50, 4'b0000);
        draw_box(80, 50, 3'b111, 12, 1'b0);
        load(2'd0, 8'd178, 4'b0001);
        draw_box(40, 178, 3'b010, 6, 1'b0);
`else
        load(2'd2, 8'd10, 4'b0100);
        draw_box(120, 10, 3'b010, 16, 1'b0);
        load(2'd1, 8'd50, 4'b0000);
        draw_box(80, 50, 3'b111, 16, 1'b0);
        load(2'd0, 8'd178, 4'b0001);
        draw_box(40, 178, 3'b010, 8, 1'b0);
`endif

        // Start in IDLE is ignored; last of two loads wins; loads during DRAW ignored.
        u_if.startingAddressLoaded = 1'b1;
        tick();
        u_if.startingAddressLoaded = 1'b0;
        tick();
        tick();
        chk("idle_start_busy", 32'(u_if.busy), 0);
        chk("idle_start_plot", 32'(u_if.plot), 0);
        load(2'd0, 8'd30, 4'b1000);
        load(2'd3, 8'd30, 4'b1000);
`ifdef BOX_OUTLINE_EN
        draw_box(160, 30, 3'b010, 12, 1'b1);
`else
        draw_box(160, 30, 3'b010, 16, 1'b1);
`endif
        tick();
        chk("post_busy", 32'(u_if.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
